// File: rtl/uart_defs.sv
// Shared UART constants and the TX arbiter state encoding.
// Receiver, transmitter and arbiter all import these.
package uart_defs;

   localparam int CLK_FREQ = 50_000_000;
   localparam int BAUDRATE = 115_200;
   localparam int DATA_W   = 8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SEND,
      S_START,
      S_WAIT_BUSY,
      S_WAIT_DONE
   } arb_state_t;

endpackage

// File: rtl/uart_rr_pick.sv
// Round-robin pick: first valid bit at or above ptr, wrapping.
// Purely combinational; any is set when some bit is valid.
module uart_rr_pick #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  valid,
   input  logic [IW-1:0] ptr,
   output logic [IW-1:0] idx,
   output logic          any
);

   logic [2*N-1:0] rot;
   logic [IW:0]    pos;

   assign rot = {valid, valid} >> ptr;
   assign any = |valid;

   // Scan downward so the lowest rotated offset wins
   always_comb begin
      idx = '0;
      pos = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (rot[k]) begin
            pos = {1'b0, ptr} + (IW + 1)'(k);
            if (pos >= (IW + 1)'(N)) pos = pos - (IW + 1)'(N);
            idx = pos[IW-1:0];
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between requesters.
// Grant is held for a whole packet; a stalled owner is released on timeout.
module uart_tx_arbiter #(
   parameter int NUM_REQ      = 4,
   parameter int DATA_W       = 8,
   parameter int LOCK_TIMEOUT = 1024,
   parameter int ID_W         = $clog2(NUM_REQ)
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [NUM_REQ-1:0]          req_valid,
   input  logic [NUM_REQ*DATA_W-1:0]   req_data,
   input  logic [NUM_REQ-1:0]          req_last,
   output logic [NUM_REQ-1:0]          req_ready,
   output logic                        tx_start,
   output logic [DATA_W-1:0]           tx_data,
   input  logic                        tx_busy,
   output logic                        grant_valid,
   output logic [ID_W-1:0]             grant_id,
   output logic                        timeout_pulse
);

   import uart_defs::arb_state_t;
   import uart_defs::S_IDLE;
   import uart_defs::S_SEND;
   import uart_defs::S_START;
   import uart_defs::S_WAIT_BUSY;
   import uart_defs::S_WAIT_DONE;

   localparam int CNT_W = $clog2(LOCK_TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [ID_W-1:0]  ID_MAX  = ID_W'(NUM_REQ - 1);

   arb_state_t          state;
   logic [ID_W-1:0]     rr_ptr;
   logic [ID_W-1:0]     pick_id;
   logic [ID_W-1:0]     next_ptr;
   logic                pick_any;
   logic                last_q;
   logic                hs;
   logic [CNT_W-1:0]    cnt;
   logic [NUM_REQ-1:0]  own;
   logic [DATA_W-1:0]   sel_data;
   logic                sel_last;

   uart_rr_pick #(.N(NUM_REQ), .IW(ID_W)) u_pick (
      .valid (req_valid),
      .ptr   (rr_ptr),
      .idx   (pick_id),
      .any   (pick_any)
   );

   assign own       = NUM_REQ'(1) << grant_id;
   assign req_ready = (state == S_SEND && !tx_busy) ? (req_valid & own) : '0;
   assign hs        = |req_ready;
   assign next_ptr  = (grant_id == ID_MAX) ? '0 : grant_id + 1'b1;

   always_comb begin
      sel_data = '0;
      sel_last = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (own[i]) begin
            sel_data = req_data[i*DATA_W +: DATA_W];
            sel_last = req_last[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= S_IDLE;
         tx_start      <= 1'b0;
         tx_data       <= '0;
         grant_valid   <= 1'b0;
         grant_id      <= '0;
         timeout_pulse <= 1'b0;
         rr_ptr        <= '0;
         cnt           <= '0;
         last_q        <= 1'b0;
      end else begin
         tx_start      <= 1'b0;
         timeout_pulse <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (pick_any) begin
                  grant_id    <= pick_id;
                  grant_valid <= 1'b1;
                  cnt         <= '0;
                  state       <= S_SEND;
               end
            end
            S_SEND: begin
               // A handshake on the timeout cycle still wins
               if (hs) begin
                  tx_data  <= sel_data;
                  last_q   <= sel_last;
                  cnt      <= '0;
                  tx_start <= 1'b1;
                  state    <= S_START;
               end else if (cnt == CNT_MAX) begin
                  grant_valid   <= 1'b0;
                  rr_ptr        <= next_ptr;
                  timeout_pulse <= 1'b1;
                  state         <= S_IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_START: state <= S_WAIT_BUSY;
            S_WAIT_BUSY: begin
               if (tx_busy) state <= S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
               if (!tx_busy) begin
                  if (last_q) begin
                     grant_valid <= 1'b0;
                     rr_ptr      <= next_ptr;
                     state       <= S_IDLE;
                  end else begin
                     cnt   <= '0;
                     state <= S_SEND;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
